// File: rtl/dmem_mmio_responder.sv
// Data-port responder: byte-lane word RAM, a 4-word MMIO window (status, cycle/store
// counters, W1C error flags) and a store-trace FIFO drained over valid/ready.
module dmem_mmio_responder #(
    parameter int          MEM_WORDS   = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h400,
    parameter logic [31:0] DONE_MAGIC  = 32'h42,
    parameter int          TRACE_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] d_mem_addr,
    input  logic [31:0] d_mem_wdata,
    input  logic [3:0]  d_mem_wen,
    output logic [31:0] d_mem_rdata,
    output logic        done,
    output logic [2:0]  err,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic [3:0]  trace_wen
);

    localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int          PW        = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
    localparam logic [31:0] RAM_WORDS = 32'(MEM_WORDS);
    localparam logic [PW:0] FIFO_FULL = (PW + 1)'(TRACE_DEPTH);

    // Address decode
    logic [29:0]   word_addr;
    logic [AW-1:0] ram_idx;
    logic [1:0]    mmio_off;
    logic          is_store;
    logic          is_mmio;
    logic          in_ram;
    logic          full_word;
    logic          store_ok;
    logic          ram_we;
    logic          mmio_wr;
    logic          mmio_partial;
    logic          oor_store;
    logic          unused_addr_lsbs;

    assign word_addr        = d_mem_addr[31:2];
    assign ram_idx          = d_mem_addr[AW+1:2];
    assign mmio_off         = d_mem_addr[3:2];
    assign is_store         = |d_mem_wen;
    assign is_mmio          = (d_mem_addr[31:4] == MMIO_BASE[31:4]);
    assign in_ram           = ({2'b00, word_addr} < RAM_WORDS);
    assign full_word        = (d_mem_wen == 4'hF);
    assign store_ok         = is_store && (is_mmio || in_ram);
    assign ram_we           = rst_n && is_store && !is_mmio && in_ram;
    assign mmio_wr          = is_store && is_mmio && full_word;
    assign mmio_partial     = is_store && is_mmio && !full_word;
    assign oor_store        = is_store && !is_mmio && !in_ram;
    assign unused_addr_lsbs = ^d_mem_addr[1:0];

    // Word RAM, never reset
    logic [31:0] ram_q [MEM_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we && d_mem_wen[i]) begin
                ram_q[ram_idx][8*i +: 8] <= d_mem_wdata[8*i +: 8];
            end
        end
    end

    // Control and MMIO state
    logic [31:0] status_q, status_d;
    logic [31:0] cycles_q, cycles_d;
    logic [31:0] stores_q, stores_d;
    logic [2:0]  err_q, err_d;
    logic        done_q, done_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;

    logic        pop;
    logic        push;
    logic        fifo_full;
    logic        overflow;
    logic [2:0]  err_set;
    logic [2:0]  err_clr;

    logic [31:0] tr_addr_q [TRACE_DEPTH];
    logic [31:0] tr_data_q [TRACE_DEPTH];
    logic [3:0]  tr_wen_q  [TRACE_DEPTH];

    always_comb begin
        pop       = (count_q != '0) && trace_ready;
        fifo_full = (count_q == FIFO_FULL);
        push      = store_ok && (!fifo_full || pop);
        overflow  = store_ok && fifo_full && !pop;

        status_d = status_q;
        if (mmio_wr && mmio_off == 2'd0) begin
            status_d = d_mem_wdata;
        end

        done_d = done_q;
        if (mmio_wr && mmio_off == 2'd0 && d_mem_wdata == DONE_MAGIC) begin
            done_d = 1'b1;
        end

        cycles_d = cycles_q;
        if (!done_q && cycles_q != 32'hFFFF_FFFF) begin
            cycles_d = cycles_q + 32'd1;
        end

        stores_d = stores_q;
        if (store_ok && stores_q != 32'hFFFF_FFFF) begin
            stores_d = stores_q + 32'd1;
        end

        // Set is applied after clear so a simultaneous set wins
        err_clr = (mmio_wr && mmio_off == 2'd3) ? d_mem_wdata[2:0] : 3'b000;
        err_set = {mmio_partial, overflow, oor_store};
        err_d   = (err_q & ~err_clr) | err_set;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status_q <= 32'h0;
            cycles_q <= 32'h0;
            stores_q <= 32'h0;
            err_q    <= 3'b000;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            status_q <= status_d;
            cycles_q <= cycles_d;
            stores_q <= stores_d;
            err_q    <= err_d;
            done_q   <= done_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Trace payload storage; pointers alone decide what is live
    always_ff @(posedge clk) begin
        if (push) begin
            tr_addr_q[wr_ptr_q] <= d_mem_addr;
            tr_data_q[wr_ptr_q] <= d_mem_wdata;
            tr_wen_q[wr_ptr_q]  <= d_mem_wen;
        end
    end

    // Combinational read: MMIO overrides RAM, anything else reads zero
    always_comb begin
        d_mem_rdata = 32'h0;
        if (is_mmio) begin
            case (mmio_off)
                2'd0:    d_mem_rdata = status_q;
                2'd1:    d_mem_rdata = cycles_q;
                2'd2:    d_mem_rdata = stores_q;
                default: d_mem_rdata = {29'h0, err_q};
            endcase
        end else if (in_ram) begin
            d_mem_rdata = ram_q[ram_idx];
        end
    end

    assign done        = done_q;
    assign err         = err_q;
    assign trace_valid = (count_q != '0);
    assign trace_addr  = tr_addr_q[rd_ptr_q];
    assign trace_data  = tr_data_q[rd_ptr_q];
    assign trace_wen   = tr_wen_q[rd_ptr_q];

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: RAM lanes, MMIO registers, done marker,
// trace FIFO overflow/ordering, out-of-range stores, W1C and mid-run reset.
module tb_dmem_mmio_responder;

    logic        clk;
    logic        rst_n;
    logic [31:0] d_mem_addr;
    logic [31:0] d_mem_wdata;
    logic [3:0]  d_mem_wen;
    logic [31:0] d_mem_rdata;
    logic        done;
    logic [2:0]  err;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    logic [3:0]  trace_wen;

    int tests_run    = 0;
    int tests_failed = 0;

    dmem_mmio_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .d_mem_addr  (d_mem_addr),
        .d_mem_wdata (d_mem_wdata),
        .d_mem_wen   (d_mem_wen),
        .d_mem_rdata (d_mem_rdata),
        .done        (done),
        .err         (err),
        .trace_valid (trace_valid),
        .trace_ready (trace_ready),
        .trace_addr  (trace_addr),
        .trace_data  (trace_data),
        .trace_wen   (trace_wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        d_mem_addr  = a;
        d_mem_wdata = d;
        d_mem_wen   = w;
        step();
        d_mem_wen   = 4'b0000;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        d_mem_addr = a;
        d_mem_wen  = 4'b0000;
        #1;
        v = d_mem_rdata;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        apply_reset();
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
        tests_run++; if (err !== 3'b000) begin tests_failed++; $display("FAIL reset_err: got %b expected 000", err); end
        tests_run++; if (trace_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_tvalid: got %b expected 0", trace_valid); end
        rd(32'h400, v);
        tests_run++; if (v !== 32'h0) begin tests_failed++; $display("FAIL reset_status: got %h expected 0", v); end
        rd(32'h404, v);
        tests_run++; if (v !== 32'h0) begin tests_failed++; $display("FAIL reset_cycles: got %h expected 0", v); end
        rd(32'h408, v);
        tests_run++; if (v !== 32'h0) begin tests_failed++; $display("FAIL reset_stores: got %h expected 0", v); end
    endtask

    task automatic test_ram_store();
        logic [31:0] v;
        st(32'h300, 32'd3, 4'hF);
        rd(32'h300, v);
        tests_run++; if (v !== 32'd3) begin tests_failed++; $display("FAIL ram_read: got %h expected 3", v); end
        tests_run++; if (trace_valid !== 1'b1) begin tests_failed++; $display("FAIL t1_tvalid: got %b expected 1", trace_valid); end
        tests_run++; if ({trace_addr, trace_data, trace_wen} !== {32'h300, 32'd3, 4'hF}) begin
            tests_failed++; $display("FAIL t1_trace: got %h/%h/%b expected 300/3/1111", trace_addr, trace_data, trace_wen); end
        rd(32'h408, v);
        tests_run++; if (v !== 32'd1) begin tests_failed++; $display("FAIL t1_stores: got %h expected 1", v); end
        trace_ready = 1'b1;
        step();
        trace_ready = 1'b0;
        tests_run++; if (trace_valid !== 1'b0) begin tests_failed++; $display("FAIL t1_drained: got %b expected 0", trace_valid); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] v;
        st(32'h304, 32'h1122_3344, 4'hF);
        d_mem_addr  = 32'h304;
        d_mem_wdata = 32'hAABB_CCDD;
        d_mem_wen   = 4'b0010;
        #1;
        tests_run++; if (d_mem_rdata !== 32'h1122_3344) begin tests_failed++; $display("FAIL pre_store_read: got %h expected 11223344", d_mem_rdata); end
        step();
        d_mem_wen = 4'b0000;
        rd(32'h304, v);
        tests_run++; if (v !== 32'h1122_CC44) begin tests_failed++; $display("FAIL lane_merge: got %h expected 1122cc44", v); end
        trace_ready = 1'b1;
        step();
        tests_run++; if ({trace_valid, trace_addr, trace_data, trace_wen} !== {1'b1, 32'h304, 32'hAABB_CCDD, 4'b0010}) begin
            tests_failed++; $display("FAIL lane_trace: got %b/%h/%h/%b expected 1/304/aabbccdd/0010", trace_valid, trace_addr, trace_data, trace_wen); end
        step();
        trace_ready = 1'b0;
        tests_run++; if (trace_valid !== 1'b0) begin tests_failed++; $display("FAIL t2_drained: got %b expected 0", trace_valid); end
    endtask

    task automatic test_done();
        logic [31:0] k;
        logic [31:0] v;
        rd(32'h404, k);
        st(32'h400, 32'h42, 4'hF);
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL done_set: got %b expected 1", done); end
        rd(32'h404, v);
        tests_run++; if (v !== k + 32'd1) begin tests_failed++; $display("FAIL cycles_at_done: got %h expected %h", v, k + 32'd1); end
        repeat (50) step();
        rd(32'h404, v);
        tests_run++; if (v !== k + 32'd1) begin tests_failed++; $display("FAIL cycles_frozen: got %h expected %h", v, k + 32'd1); end
        st(32'h400, 32'h0, 4'hF);
        rd(32'h400, v);
        tests_run++; if (v !== 32'h0) begin tests_failed++; $display("FAIL status_rewrite: got %h expected 0", v); end
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL done_sticky: got %b expected 1", done); end
        st(32'h400, 32'hFF, 4'b0001);
        rd(32'h400, v);
        tests_run++; if (v !== 32'h0) begin tests_failed++; $display("FAIL status_partial: got %h expected 0", v); end
        tests_run++; if (err !== 3'b100) begin tests_failed++; $display("FAIL partial_err: got %b expected 100", err); end
        rd(32'h408, v);
        tests_run++; if (v !== 32'd6) begin tests_failed++; $display("FAIL t3_stores: got %h expected 6", v); end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        int n;
        apply_reset();
        trace_ready = 1'b0;
        for (int i = 0; i < 8; i++) st(32'(4 * i), 32'(i), 4'hF);
        tests_run++; if (err !== 3'b000) begin tests_failed++; $display("FAIL full_no_ovf: got %b expected 000", err); end
        st(32'h20, 32'd8, 4'hF);
        tests_run++; if (err !== 3'b010) begin tests_failed++; $display("FAIL ovf_err: got %b expected 010", err); end
        rd(32'h408, v);
        tests_run++; if (v !== 32'd9) begin tests_failed++; $display("FAIL ovf_stores: got %h expected 9", v); end
        trace_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tests_run++; if ({trace_valid, trace_addr} !== {1'b1, 32'(4 * i)}) begin
                tests_failed++; $display("FAIL drain_order[%0d]: got %b/%h expected 1/%h", i, trace_valid, trace_addr, 32'(4 * i)); end
            step();
        end
        trace_ready = 1'b0;
        tests_run++; if (trace_valid !== 1'b0) begin tests_failed++; $display("FAIL drain_empty: got %b expected 0", trace_valid); end
        st(32'h40C, 32'h2, 4'hF);
        for (int i = 0; i < 7; i++) st(32'h100 + 32'(4 * i), 32'(i), 4'hF);
        tests_run++; if (err !== 3'b000) begin tests_failed++; $display("FAIL refill_err: got %b expected 000", err); end
        trace_ready = 1'b1;
        st(32'h200, 32'h55, 4'hF);
        tests_run++; if (err !== 3'b000) begin tests_failed++; $display("FAIL push_pop_full: got %b expected 000", err); end
        n = 0;
        while (trace_valid && n < 20) begin
            n++;
            step();
        end
        trace_ready = 1'b0;
        tests_run++; if (n !== 8) begin tests_failed++; $display("FAIL full_count: got %0d expected 8", n); end
        rd(32'h408, v);
        tests_run++; if (v !== 32'd18) begin tests_failed++; $display("FAIL t4_stores: got %h expected 18", v); end
    endtask

    task automatic test_oor_w1c();
        logic [31:0] v;
        apply_reset();
        trace_ready = 1'b0;
        st(32'hFFC, 32'h5A5A_5A5A, 4'hF);
        rd(32'hFFC, v);
        tests_run++; if (v !== 32'h5A5A_5A5A) begin tests_failed++; $display("FAIL ram_top: got %h expected 5a5a5a5a", v); end
        for (int i = 0; i < 8; i++) st(32'(4 * i), 32'(i), 4'hF);
        tests_run++; if (err !== 3'b010) begin tests_failed++; $display("FAIL t5_ovf: got %b expected 010", err); end
        st(32'h1000, 32'hDEAD_BEEF, 4'hF);
        tests_run++; if (err !== 3'b011) begin tests_failed++; $display("FAIL oor_err: got %b expected 011", err); end
        rd(32'h408, v);
        tests_run++; if (v !== 32'd9) begin tests_failed++; $display("FAIL oor_stores: got %h expected 9", v); end
        rd(32'h1000, v);
        tests_run++; if (v !== 32'h0) begin tests_failed++; $display("FAIL oor_read: got %h expected 0", v); end
        st(32'h40C, 32'h1, 4'hF);
        tests_run++; if (err !== 3'b010) begin tests_failed++; $display("FAIL w1c_bit0: got %b expected 010", err); end
        st(32'h40C, 32'h2, 4'hF);
        tests_run++; if (err !== 3'b010) begin tests_failed++; $display("FAIL set_wins: got %b expected 010", err); end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] v;
        apply_reset();
        trace_ready = 1'b0;
        st(32'h300, 32'd3, 4'hF);
        st(32'h308, 32'h77, 4'hF);
        st(32'h400, 32'h42, 4'hF);
        st(32'h404, 32'h1, 4'b0011);
        tests_run++; if ({done, err, trace_valid} !== {1'b1, 3'b100, 1'b1}) begin
            tests_failed++; $display("FAIL pre_reset: got %b/%b/%b expected 1/100/1", done, err, trace_valid); end
        rst_n       = 1'b0;
        d_mem_addr  = 32'h308;
        d_mem_wdata = 32'h99;
        d_mem_wen   = 4'hF;
        step();
        d_mem_wen   = 4'b0000;
        rst_n       = 1'b1;
        tests_run++; if ({trace_valid, done, err} !== {1'b0, 1'b0, 3'b000}) begin
            tests_failed++; $display("FAIL post_reset_ctrl: got %b/%b/%b expected 0/0/000", trace_valid, done, err); end
        rd(32'h404, v);
        tests_run++; if (v !== 32'h0) begin tests_failed++; $display("FAIL post_reset_cycles: got %h expected 0", v); end
        rd(32'h408, v);
        tests_run++; if (v !== 32'h0) begin tests_failed++; $display("FAIL post_reset_stores: got %h expected 0", v); end
        rd(32'h300, v);
        tests_run++; if (v !== 32'd3) begin tests_failed++; $display("FAIL ram_retained: got %h expected 3", v); end
        rd(32'h308, v);
        tests_run++; if (v !== 32'h77) begin tests_failed++; $display("FAIL store_in_reset: got %h expected 77", v); end
    endtask

    initial begin
        rst_n       = 1'b0;
        d_mem_addr  = 32'h0;
        d_mem_wdata = 32'h0;
        d_mem_wen   = 4'b0000;
        trace_ready = 1'b0;
        test_reset();
        test_ram_store();
        test_byte_lanes();
        test_done();
        test_overflow();
        test_oor_w1c();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
